mprj_seq_monitor: RTL and testbench
===================================

MPRJ_SEQ_MONITOR -- requirements
Module: mprj_seq_monitor

Interface
REQ-001 Parameter WIDTH, default 16: width of the monitored bus.
REQ-002 Parameter DEPTH, default 8: maximum number of sequence steps.
REQ-003 Parameter TMO_W, default 24: width of the per-step timeout counter.
REQ-004 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 mon_i  input  WIDTH  monitored bus, e.g. checkbits or status; synchronous to wb_clk_i.
REQ-007 prog_we_i, prog_addr_i[$clog2(DEPTH)], prog_val_i[WIDTH], prog_mask_i[WIDTH]  input  step-table write port.
REQ-008 num_steps_i  input  $clog2(DEPTH+1)  number of active steps.
REQ-009 tmo_limit_i  input  TMO_W  per-step timeout in cycles; 0 disables the timeout.
REQ-010 start_i, abort_i  input  1  run control.
REQ-011 busy_o, pass_o, fail_o, tmo_o, hit_o  output  1  status flags; hit_o is a one-cycle pulse.
REQ-012 step_o  output  $clog2(DEPTH)  index of the step currently awaited.
REQ-013 fail_val_o  output  WIDTH  value of mon_i captured on failure.

Function
REQ-014 Step k matches when (mon_i & mask[k]) == (val[k] & mask[k]).
REQ-015 The FSM has states IDLE, RUN, PASS and FAIL; busy_o=RUN, pass_o=PASS, fail_o=FAIL.
REQ-016 In IDLE, PASS or FAIL, start_i enters RUN next cycle with step_o=0, counter=0, and tmo_o, pass_o and fail_o cleared.
REQ-017 start_i with num_steps_i==0 enters PASS directly.
REQ-018 num_steps_i > DEPTH is clamped to DEPTH; num_steps_i is sampled at start and held for the run.
REQ-019 In RUN, a match on the sampled edge pulses hit_o the following cycle, increments step_o and zeroes the counter.
REQ-020 A match on the last step (step_o==num_steps-1) enters PASS; step_o holds its last value.
REQ-021 Steps are strictly ordered and advance at most one per cycle; the next step is evaluated from the next cycle onward.
REQ-022 In RUN without a match the counter increments; when it reaches a nonzero tmo_limit_i, the FSM enters FAIL with tmo_o=1.
REQ-023 abort_i in RUN enters FAIL with tmo_o=0.
REQ-024 abort_i takes priority over a match; a match takes priority over a timeout in the same cycle.
REQ-025 start_i is ignored while in RUN.
REQ-026 Table writes are accepted only outside RUN; writes with prog_addr_i >= DEPTH are ignored.
REQ-027 The counter saturates rather than wrapping.

Reset
REQ-028 On wb_rst_i the FSM enters IDLE, all outputs go to 0, the counter clears, and every table entry resets to val=0, mask=0, so unprogrammed steps match anything.
REQ-029 Reset asserted mid-RUN abandons the run immediately with no PASS or FAIL indication.

Configuration
REQ-030 With MPRJ_SEQMON_CAPTURE_EN defined, fail_val_o loads mon_i on entry to FAIL and holds that value until the next start or reset.
REQ-031 Without MPRJ_SEQMON_CAPTURE_EN, fail_val_o is constant 0 and no capture register is implemented; all other behaviour is identical.

Structure
REQ-032 Package mprj_seqmon_pkg holds the FSM state encoding and the default parameter constants.
REQ-033 Sub-module mprj_seqmon_table implements a DEPTH x 2*WIDTH register file with one write port and one combinational read port indexed by step_o.

Verification
REQ-034 Program steps AB40/FFFF, 0009/FFFF, AB51/FFFF with num=3 and tmo=1000; drive AB40, 1234, 0009, AB51 -> hit_o three times, then pass_o=1 and step_o=2.
REQ-035 Program step 0 as 000A/000F; drive 5A3A -> match via mask, pass_o.
REQ-036 Set tmo=50; drive a non-matching value -> fail_o=1 and tmo_o=1 exactly 50 cycles after start; with the macro, fail_val_o equals the driven value.
REQ-037 Assert abort_i and a matching value in the same cycle -> fail_o=1, tmo_o=0, no hit_o.
REQ-038 Pulse wb_rst_i mid-RUN at step 1 -> all outputs 0 and state IDLE; a subsequent start restarts at step 0.
REQ-039 Start with num_steps_i=0 -> pass_o next cycle; a prog_we_i during RUN -> table unchanged.

Source files
------------

// File: rtl/mprj_seqmon_pkg.sv
// Shared FSM state encoding and default parameter constants for the sequence monitor.
package mprj_seqmon_pkg;

  localparam int SEQMON_WIDTH_DEF = 16;
  localparam int SEQMON_DEPTH_DEF = 8;
  localparam int SEQMON_TMO_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } seqmon_state_e;

endpackage

// File: rtl/mprj_seqmon_table.sv
// Step table: DEPTH entries of {value, mask}, one write port, one combinational read port.
module mprj_seqmon_table
  import mprj_seqmon_pkg::*;
#(
  parameter  int WIDTH = SEQMON_WIDTH_DEF,
  parameter  int DEPTH = SEQMON_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wval_i,
  input  logic [WIDTH-1:0] wmask_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rval_o,
  output logic [WIDTH-1:0] rmask_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] val_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic             wInRange;
  logic             rInRange;

  assign wInRange = ({1'b0, waddr_i} < DEPTH_L);
  assign rInRange = ({1'b0, raddr_i} < DEPTH_L);

  // A cleared mask means an unprogrammed step matches any bus value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else if (we_i && wInRange) begin
      val_q[waddr_i]  <= wval_i;
      mask_q[waddr_i] <= wmask_i;
    end
  end

  assign rval_o  = rInRange ? val_q[raddr_i]  : '0;
  assign rmask_o = rInRange ? mask_q[raddr_i] : '0;

endmodule

// File: rtl/mprj_seq_monitor.sv
// Ordered masked-match sequence monitor with per-step timeout and abort.
// Define MPRJ_SEQMON_CAPTURE_EN to capture mon_i into fail_val_o on entry to FAIL.
module mprj_seq_monitor
  import mprj_seqmon_pkg::*;
#(
  parameter  int WIDTH = SEQMON_WIDTH_DEF,
  parameter  int DEPTH = SEQMON_DEPTH_DEF,
  parameter  int TMO_W = SEQMON_TMO_W_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] mon_i,
  input  logic             prog_we_i,
  input  logic [AW-1:0]    prog_addr_i,
  input  logic [WIDTH-1:0] prog_val_i,
  input  logic [WIDTH-1:0] prog_mask_i,
  input  logic [NW-1:0]    num_steps_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             tmo_o,
  output logic             hit_o,
  output logic [AW-1:0]    step_o,
  output logic [WIDTH-1:0] fail_val_o
);

  seqmon_state_e    state_q;
  logic [AW-1:0]    stepIdx_q;
  logic [NW-1:0]    numSteps_q;
  logic [TMO_W-1:0] tmoCnt_q;
  logic [TMO_W-1:0] tmoCnt_d;
  logic             busy_q;
  logic             pass_q;
  logic             fail_q;
  logic             tmo_q;
  logic             hit_q;

  logic [WIDTH-1:0] stepVal;
  logic [WIDTH-1:0] stepMask;
  logic [NW-1:0]    numClamped;
  logic             stepMatch;
  logic             lastStep;
  logic             tmoExpire;
  logic             startAccept;
  logic             failEntry;

  mprj_seqmon_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .we_i    (prog_we_i && (state_q != ST_RUN)),
    .waddr_i (prog_addr_i),
    .wval_i  (prog_val_i),
    .wmask_i (prog_mask_i),
    .raddr_i (stepIdx_q),
    .rval_o  (stepVal),
    .rmask_o (stepMask)
  );

  // Abort outranks a match, and a match outranks a timeout, so failEntry excludes the match case only for timeouts.
  always_comb begin
    numClamped  = (num_steps_i > NW'(DEPTH)) ? NW'(DEPTH) : num_steps_i;
    stepMatch   = ((mon_i ^ stepVal) & stepMask) == '0;
    lastStep    = (NW'(stepIdx_q) == (numSteps_q - NW'(1)));
    tmoCnt_d    = (&tmoCnt_q) ? tmoCnt_q : tmoCnt_q + TMO_W'(1);
    tmoExpire   = (tmo_limit_i != '0) && (tmoCnt_d >= tmo_limit_i);
    startAccept = start_i && (state_q != ST_RUN);
    failEntry   = (state_q == ST_RUN) && (abort_i || (!stepMatch && tmoExpire));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      stepIdx_q  <= '0;
      numSteps_q <= '0;
      tmoCnt_q   <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (failEntry) begin
            state_q <= ST_FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
            tmo_q   <= !abort_i;
          end else if (stepMatch) begin
            hit_q    <= 1'b1;
            tmoCnt_q <= '0;
            if (lastStep) begin
              state_q <= ST_PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              stepIdx_q <= stepIdx_q + AW'(1);
            end
          end else begin
            tmoCnt_q <= tmoCnt_d;
          end
        end
        default: begin
          if (startAccept) begin
            stepIdx_q  <= '0;
            tmoCnt_q   <= '0;
            numSteps_q <= numClamped;
            tmo_q      <= 1'b0;
            fail_q     <= 1'b0;
            if (numClamped == '0) begin
              state_q <= ST_PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign pass_o = pass_q;
  assign fail_o = fail_q;
  assign tmo_o  = tmo_q;
  assign hit_o  = hit_q;
  assign step_o = stepIdx_q;

`ifdef MPRJ_SEQMON_CAPTURE_EN
  logic [WIDTH-1:0] failVal_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      failVal_q <= '0;
    end else if (startAccept) begin
      failVal_q <= '0;
    end else if (failEntry) begin
      failVal_q <= mon_i;
    end
  end

  assign fail_val_o = failVal_q;
`else
  assign fail_val_o = '0;
`endif

endmodule

// File: tb/tb_mprj_seq_monitor.sv
// Scoreboard bench for mprj_seq_monitor: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_mprj_seq_monitor;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 8;
  localparam int TMO_W   = 24;
  localparam int EV_HIT  = 0;
  localparam int EV_PASS = 1;
  localparam int EV_FAIL = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [WIDTH-1:0]  monI = '0;
  logic              progWe = 1'b0;
  logic [2:0]        progAddr = '0;
  logic [WIDTH-1:0]  progVal = '0;
  logic [WIDTH-1:0]  progMask = '0;
  logic [3:0]        numSteps = '0;
  logic [TMO_W-1:0]  tmoLimit = '0;
  logic              startI = 1'b0;
  logic              abortI = 1'b0;
  logic              busyO, passO, failO, tmoO, hitO;
  logic [2:0]        stepO;
  logic [WIDTH-1:0]  failValO;

  typedef struct {
    int kind;
    int step;
    int tmo;
    int busy;
    int fval;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prevPass = 1'b0;
  logic prevFail = 1'b0;

  mprj_seq_monitor #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TMO_W (TMO_W)
  ) dut (
    .wb_clk_i    (clock),
    .wb_rst_i    (reset),
    .mon_i       (monI),
    .prog_we_i   (progWe),
    .prog_addr_i (progAddr),
    .prog_val_i  (progVal),
    .prog_mask_i (progMask),
    .num_steps_i (numSteps),
    .tmo_limit_i (tmoLimit),
    .start_i     (startI),
    .abort_i     (abortI),
    .busy_o      (busyO),
    .pass_o      (passO),
    .fail_o      (failO),
    .tmo_o       (tmoO),
    .hit_o       (hitO),
    .step_o      (stepO),
    .fail_val_o  (failValO)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int expFv(input int v);
`ifdef MPRJ_SEQMON_CAPTURE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic pushExp(input int kind, input int step, input int tmo, input int busy,
                         input int fval, input int c);
    expQ.push_back('{kind: kind, step: step, tmo: tmo, busy: busy, fval: fval, cyc: c});
  endtask

  task automatic handleEvent(input int kind);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event actual=%0d expected=none", kind);
    end else begin
      e = expQ.pop_front();
      checkOutput("ev_kind", kind, e.kind);
      checkOutput("ev_step", int'(stepO), e.step);
      checkOutput("ev_tmo", int'(tmoO), e.tmo);
      checkOutput("ev_busy", int'(busyO), e.busy);
      checkOutput("ev_failval", int'(failValO), e.fval);
      if (e.cyc >= 0) checkOutput("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: hit pulses and rising edges of pass/fail are the DUT's output events.
  always @(negedge clock) begin
    if (!reset) begin
      if (hitO) handleEvent(EV_HIT);
      if (passO && !prevPass) handleEvent(EV_PASS);
      if (failO && !prevFail) handleEvent(EV_FAIL);
    end
    prevPass = passO;
    prevFail = failO;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] m, input logic st, input logic ab);
    monI   = m;
    startI = st;
    abortI = ab;
    tick();
    startI = 1'b0;
    abortI = 1'b0;
  endtask

  task automatic progStep(input int a, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] mk);
    progWe   = 1'b1;
    progAddr = 3'(a);
    progVal  = v;
    progMask = mk;
    tick();
    progWe   = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(passO || failO) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_done"}, int'(passO | failO), 1);
    tick();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busyO), 0);
    checkOutput({tag, "_pass"}, int'(passO), 0);
    checkOutput({tag, "_fail"}, int'(failO), 0);
    checkOutput({tag, "_tmo"}, int'(tmoO), 0);
    checkOutput({tag, "_hit"}, int'(hitO), 0);
    checkOutput({tag, "_step"}, int'(stepO), 0);
    checkOutput({tag, "_failval"}, int'(failValO), 0);
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkAllZero("reset");

    // Three exact-match steps with a non-matching value in between.
    progStep(0, 16'hAB40, 16'hFFFF);
    progStep(1, 16'h0009, 16'hFFFF);
    progStep(2, 16'hAB51, 16'hFFFF);
    numSteps = 4'd3;
    tmoLimit = 24'd1000;
    pushExp(EV_HIT, 1, 0, 1, 0, -1);
    pushExp(EV_HIT, 2, 0, 1, 0, -1);
    pushExp(EV_HIT, 2, 0, 0, 0, -1);
    pushExp(EV_PASS, 2, 0, 0, 0, -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'hAB40, 1'b0, 1'b0);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0009, 1'b0, 1'b0);
    applyStimulus(16'hAB51, 1'b0, 1'b0);
    tick();
    tick();

    // Masked match on the low nibble only.
    progStep(0, 16'h000A, 16'h000F);
    numSteps = 4'd1;
    pushExp(EV_HIT, 0, 0, 0, 0, -1);
    pushExp(EV_PASS, 0, 0, 0, 0, -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h5A3A, 1'b0, 1'b0);
    tick();
    tick();

    // Timeout exactly 50 cycles after the start edge.
    tmoLimit = 24'd50;
    c0 = cyc;
    pushExp(EV_FAIL, 0, 1, 0, expFv(32'h1235), c0 + 51);
    applyStimulus(16'h1235, 1'b1, 1'b0);
    waitDone("tmo", 80);

    // Abort and match in the same cycle: abort wins, no hit.
    tmoLimit = 24'd1000;
    pushExp(EV_FAIL, 0, 0, 0, expFv(32'h000A), -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h000A, 1'b0, 1'b1);
    tick();
    tick();

    // Reset at step 1, then restart against the cleared table.
    progStep(0, 16'hAB40, 16'hFFFF);
    numSteps = 4'd3;
    pushExp(EV_HIT, 1, 0, 1, 0, -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'hAB40, 1'b0, 1'b0);
    tick();
    pulseReset();
    checkAllZero("midrun_reset");
    pushExp(EV_HIT, 1, 0, 1, 0, -1);
    pushExp(EV_HIT, 2, 0, 1, 0, -1);
    pushExp(EV_HIT, 2, 0, 0, 0, -1);
    pushExp(EV_PASS, 2, 0, 0, 0, -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("restart_busy", int'(busyO), 1);
    checkOutput("restart_step", int'(stepO), 0);
    waitDone("restart", 20);

    // num_steps above DEPTH runs exactly DEPTH steps.
    pulseReset();
    numSteps = 4'd15;
    tmoLimit = 24'd0;
    for (int k = 1; k <= 7; k++) pushExp(EV_HIT, k, 0, 1, 0, -1);
    pushExp(EV_HIT, 7, 0, 0, 0, -1);
    pushExp(EV_PASS, 7, 0, 0, 0, -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    waitDone("clamp", 30);

    // Table write during RUN is dropped; timeout disabled; then abort.
    progStep(0, 16'h0001, 16'hFFFF);
    progStep(1, 16'h0002, 16'hFFFF);
    numSteps = 4'd2;
    tmoLimit = 24'd0;
    pushExp(EV_FAIL, 0, 0, 0, expFv(32'h0000), -1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    progStep(0, 16'h0000, 16'hFFFF);
    repeat (40) tick();
    checkOutput("we_ignored_busy", int'(busyO), 1);
    checkOutput("we_ignored_step", int'(stepO), 0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    tick();
    tick();

    // Zero steps: PASS on the cycle after start.
    numSteps = 4'd0;
    c0 = cyc;
    pushExp(EV_PASS, 0, 0, 0, 0, c0 + 1);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("zero_fail", int'(failO), 0);

    tick();
    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
